// File: rtl/lieat_div_pkg.sv
// Shared definitions for the radix-4 SRT divider: quotient digit encoding
// (shared with the sign coder) and the OTFC state enum.
package lieat_div_pkg;

   localparam int QUOT_NEG_2 = 0;
   localparam int QUOT_NEG_1 = 1;
   localparam int QUOT_ZERO  = 2;
   localparam int QUOT_POS_1 = 3;
   localparam int QUOT_POS_2 = 4;

   typedef enum logic [1:0] {
      OTFC_IDLE = 2'd0,
      OTFC_ITER = 2'd1,
      OTFC_FIN  = 2'd2,
      OTFC_OUT  = 2'd3
   } otfc_state_e;

endpackage

// File: rtl/lieat_radix_4_otfc_step.sv
// One radix-4 on-the-fly conversion step: (Q, QM, one-hot digit) -> next Q/QM.
// Non-one-hot digits are converted as 0 and flagged.
module lieat_radix_4_otfc_step
   import lieat_div_pkg::*;
#(
   parameter int QUOT_W = 54
) (
   input  logic [QUOT_W-1:0] q,
   input  logic [QUOT_W-1:0] qm,
   input  logic [4:0]        quot,
   output logic [QUOT_W-1:0] q_nxt,
   output logic [QUOT_W-1:0] qm_nxt,
   output logic              onehot_err
);

   logic onehot;

   assign onehot = (quot != 5'd0) && ((quot & (quot - 5'd1)) == 5'd0);

   always_comb begin
      // digit 0 is also the fallback for malformed digits
      q_nxt      = {q[QUOT_W-3:0], 2'b00};
      qm_nxt     = {qm[QUOT_W-3:0], 2'b11};
      onehot_err = !onehot;
      if (onehot) begin
         if (quot[QUOT_POS_2]) begin
            q_nxt  = {q[QUOT_W-3:0], 2'b10};
            qm_nxt = {q[QUOT_W-3:0], 2'b01};
         end else if (quot[QUOT_POS_1]) begin
            q_nxt  = {q[QUOT_W-3:0], 2'b01};
            qm_nxt = {q[QUOT_W-3:0], 2'b00};
         end else if (quot[QUOT_NEG_1]) begin
            q_nxt  = {qm[QUOT_W-3:0], 2'b11};
            qm_nxt = {qm[QUOT_W-3:0], 2'b10};
         end else if (quot[QUOT_NEG_2]) begin
            q_nxt  = {qm[QUOT_W-3:0], 2'b10};
            qm_nxt = {qm[QUOT_W-3:0], 2'b01};
         end
      end
   end

endmodule

// File: rtl/lieat_radix_4_otfc.sv
// Sequential radix-4 OTFC: accumulates Q/QM per digit, applies the final
// remainder-sign correction and hands the quotient out over valid/ready.
module lieat_radix_4_otfc
   import lieat_div_pkg::*;
#(
   parameter int QUOT_W = 54,
   parameter int ITER_W = $clog2(QUOT_W/2+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              start_i,
   input  logic [ITER_W-1:0] iter_num_i,
   input  logic              quot_vld_i,
   input  logic [4:0]        quot_i,
   input  logic              fin_vld_i,
   input  logic              rem_neg_i,
   input  logic              res_rdy_i,
   output logic              res_vld_o,
   output logic [QUOT_W-1:0] quot_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(QUOT_W/2);

   otfc_state_e       state, state_nxt;
   logic [QUOT_W-1:0] q, qm, q_nxt, qm_nxt;
   logic [ITER_W-1:0] cnt, cnt_start;
   logic              onehot_err;

   assign cnt_start = (iter_num_i > MAX_CNT) ? MAX_CNT : iter_num_i;
   assign res_vld_o = (state == OTFC_OUT);
   assign busy_o    = (state != OTFC_IDLE);

   lieat_radix_4_otfc_step #(.QUOT_W(QUOT_W)) u_step (
      .q          (q),
      .qm         (qm),
      .quot       (quot_i),
      .q_nxt      (q_nxt),
      .qm_nxt     (qm_nxt),
      .onehot_err (onehot_err)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= OTFC_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = OTFC_IDLE;
      end else begin
         case (state)
            OTFC_IDLE: if (start_i)
                          state_nxt = (cnt_start == '0) ? OTFC_FIN : OTFC_ITER;
            OTFC_ITER: if (quot_vld_i && cnt == ITER_W'(1)) state_nxt = OTFC_FIN;
            OTFC_FIN:  if (fin_vld_i) state_nxt = OTFC_OUT;
            OTFC_OUT:  if (res_rdy_i) state_nxt = OTFC_IDLE;
            default:   state_nxt = OTFC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= '0;
         qm     <= '1;
         cnt    <= '0;
         err_o  <= 1'b0;
         quot_o <= '0;
      end else if (flush_i) begin
         // abort keeps the datapath contents; only the count is cleared
         cnt <= '0;
      end else begin
         case (state)
            OTFC_IDLE: if (start_i) begin
               q     <= '0;
               qm    <= '1;
               err_o <= 1'b0;
               cnt   <= cnt_start;
            end
            OTFC_ITER: if (quot_vld_i) begin
               q     <= q_nxt;
               qm    <= qm_nxt;
               err_o <= err_o | onehot_err;
               cnt   <= cnt - ITER_W'(1);
            end
            OTFC_FIN: if (fin_vld_i) quot_o <= rem_neg_i ? qm : q;
            default: ;
         endcase
      end
   end

endmodule
